// File: rtl/apb_timer_arbiter_pkg.sv
// Shared types and defaults for the two-requester APB timer arbiter.
// State encoding, latched command layout and default widths live here.
package apb_timer_arbiter_pkg;

  localparam int ADDR_WIDTH_DEF     = 12;
  localparam int DATA_WIDTH_DEF     = 32;
  localparam int TIMEOUT_CYCLES_DEF = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  typedef struct packed {
    logic                      write;
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic [DATA_WIDTH_DEF-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/apb_timer_arbiter_if.sv
// Requester command/response ports plus the APB3 master port of the arbiter.
// master = arbiter view, slave = requesters and the timer's APB slave.
interface apb_timer_arbiter_if
  import apb_timer_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

  logic [1:0]                 req_valid;
  logic [1:0]                 req_ready;
  logic [1:0]                 req_write;
  logic [1:0][ADDR_WIDTH-1:0] req_addr;
  logic [1:0][DATA_WIDTH-1:0] req_wdata;
  logic [1:0]                 rsp_valid;
  logic [DATA_WIDTH-1:0]      rsp_rdata;
  logic                       rsp_err;

  logic                       psel;
  logic                       penable;
  logic                       pwrite;
  logic [ADDR_WIDTH-1:0]      paddr;
  logic [DATA_WIDTH-1:0]      pwdata;
  logic [DATA_WIDTH-1:0]      prdata;
  logic                       pready;
  logic                       pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           psel, penable, pwrite, paddr, pwdata
  );

endinterface

// File: rtl/apb_timer_arbiter_rr.sv
// Two-way round-robin picker, purely combinational.
// A lone requester always wins; on a tie the one not granted last time wins.
module apb_timer_arbiter_rr (
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic       grant_valid_o,
  output logic       grant_idx_o
);

  assign grant_valid_o = |valid_i;
  assign grant_idx_o   = (&valid_i) ? ~last_grant_i : valid_i[1];

endmodule

// File: rtl/apb_timer_arbiter.sv
// Round-robin arbiter + APB3 master fronting the timer's register port.
// ACCESS-phase timeout is built only with APB_TIMER_ARBITER_TIMEOUT_EN defined.
module apb_timer_arbiter
  import apb_timer_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                reset,
  apb_timer_arbiter_if.master bus,
  output logic                timeout
);

  // The latched command is sized by the package, so the widths must agree.
  if (ADDR_WIDTH != ADDR_WIDTH_DEF || DATA_WIDTH != DATA_WIDTH_DEF ||
      TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("apb_timer_arbiter: unsupported parameter value");
  end

  state_e state_q;
  logic   psel_q;
  logic   penable_q;
  logic   gnt_q;
  logic   last_grant_q;
  cmd_t   cmd_q;
  cmd_t   cmd_d;

  logic   grant_valid;
  logic   grant_idx;
  logic   tmo_hit;
  logic   xfer_done;
  logic   grant_fire;

  apb_timer_arbiter_rr u_rr (
    .valid_i       (bus.req_valid),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (grant_valid),
    .grant_idx_o   (grant_idx)
  );

`ifdef APB_TIMER_ARBITER_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_q <= '0;
    end else if (state_q == SETUP) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ACCESS && !bus.pready) begin
      tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end
  end

  assign tmo_hit = (state_q == ACCESS) && !bus.pready &&
                   (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // A completing transfer frees the bus in the same cycle for back-to-back grants.
  assign xfer_done  = (state_q == ACCESS) && (bus.pready || tmo_hit);
  assign grant_fire = grant_valid && ((state_q == IDLE) || xfer_done);

  always_comb begin
    cmd_d.write = bus.req_write[grant_idx];
    cmd_d.addr  = bus.req_addr[grant_idx];
    cmd_d.wdata = bus.req_wdata[grant_idx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      cmd_q        <= '0;
    end else begin
      if (grant_fire) begin
        cmd_q        <= cmd_d;
        gnt_q        <= grant_idx;
        last_grant_q <= grant_idx;
      end
      case (state_q)
        IDLE: begin
          if (grant_fire) begin
            state_q <= SETUP;
            psel_q  <= 1'b1;
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
        end
        ACCESS: begin
          if (xfer_done) begin
            penable_q <= 1'b0;
            if (grant_fire) begin
              state_q <= SETUP;
            end else begin
              state_q <= IDLE;
              psel_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = cmd_q.write;
  assign bus.paddr     = cmd_q.addr;
  assign bus.pwdata    = cmd_q.wdata;

  assign bus.req_ready = {grant_fire & grant_idx, grant_fire & ~grant_idx};
  assign bus.rsp_valid = {xfer_done & gnt_q, xfer_done & ~gnt_q};
  assign bus.rsp_rdata = (xfer_done && bus.pready && !cmd_q.write) ? bus.prdata : '0;
  assign bus.rsp_err   = xfer_done & (tmo_hit | bus.pslverr);
  assign timeout       = tmo_hit;

endmodule

// File: tb/tb_apb_timer_arbiter.sv
// Directed + randomized bench for apb_timer_arbiter against a transfer-level model.
module tb_apb_timer_arbiter;

  localparam int TMO_CYC = 8;
`ifdef APB_TIMER_ARBITER_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  typedef struct packed {
    logic        w;
    logic [11:0] a;
    logic [31:0] d;
  } tcmd_t;

  logic clk = 1'b0;
  logic reset;
  logic timeout;

  apb_timer_arbiter_if bus ();

  apb_timer_arbiter #(
    .ADDR_WIDTH     (12),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (TMO_CYC)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: owner of the bus (-1 none), cycles since its grant, last granted requester.
  int    m_owner;
  int    m_age;
  int    m_last;
  tcmd_t m_cmd;

  int    glog[$];
  int    gcyc[$];
  tcmd_t cq[2][$];

  logic [1:0]  s_ready, s_rsp;
  logic [31:0] s_rdata;
  logic        s_err, s_psel, s_pen, s_tmo;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_age   = 0;
    m_last  = 1;
    m_cmd   = '0;
  endtask

  task automatic present(input int r, input tcmd_t c);
    bus.req_write[r] = c.w;
    bus.req_addr[r]  = c.a;
    bus.req_wdata[r] = c.d;
    bus.req_valid[r] = 1'b1;
  endtask

  task automatic feed();
    for (int r = 0; r < 2; r++) begin
      if (!bus.req_valid[r] && cq[r].size() > 0) present(r, cq[r].pop_front());
    end
  endtask

  // One clock: check all outputs at the falling edge, advance the model, then
  // retire the granted requester's command just after the rising edge.
  task automatic tick();
    logic       acc, tmo, done, eps;
    logic [1:0] er, ev;
    logic [31:0] ed;
    logic       ee;
    int         g;
    @(negedge clk);
    acc  = (m_owner >= 0) && (m_age >= 2);
    tmo  = TMO_ON && acc && !bus.pready && ((m_age - 1) == TMO_CYC);
    done = acc && (bus.pready || tmo);
    eps  = (m_owner >= 0) && (m_age >= 1);
    ev = 2'b00;
    if (done) ev[m_owner] = 1'b1;
    ed = (done && bus.pready && !m_cmd.w) ? bus.prdata : 32'h0;
    ee = done && (tmo || bus.pslverr);
    er = 2'b00;
    g  = -1;
    if ((m_owner < 0 || done) && bus.req_valid != 2'b00) begin
      if (bus.req_valid == 2'b11) g = 1 - m_last;
      else                        g = bus.req_valid[1] ? 1 : 0;
      er[g] = 1'b1;
    end
    s_ready = bus.req_ready;
    s_rsp   = bus.rsp_valid;
    s_rdata = bus.rsp_rdata;
    s_err   = bus.rsp_err;
    s_psel  = bus.psel;
    s_pen   = bus.penable;
    s_tmo   = timeout;
    chk("req_ready", s_ready, er);
    chk("rsp_valid", s_rsp, ev);
    chk("rsp_rdata", s_rdata, ed);
    chk("rsp_err",   s_err, ee);
    chk("psel",      s_psel, eps);
    chk("penable",   s_pen, acc);
    chk("timeout",   s_tmo, tmo);
    chk("paddr",     bus.paddr, m_cmd.a);
    chk("pwrite",    bus.pwrite, m_cmd.w);
    chk("pwdata",    bus.pwdata, m_cmd.d);
    if (g >= 0) begin
      m_owner = g;
      m_age   = 1;
      m_last  = g;
      m_cmd.w = bus.req_write[g];
      m_cmd.a = bus.req_addr[g];
      m_cmd.d = bus.req_wdata[g];
      glog.push_back(g);
      gcyc.push_back(cyc);
    end else if (done) begin
      m_owner = -1;
    end else if (m_owner >= 0) begin
      m_age++;
    end
    cyc++;
    @(posedge clk);
    #1;
    if (g >= 0) bus.req_valid[g] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int    npen, ntmo;
    tcmd_t c;

    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.prdata    = '0;
    bus.pready    = 1'b1;
    bus.pslverr   = 1'b0;
    model_reset();

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 2'b00);
    chk("rst_rsp_valid", bus.rsp_valid, 2'b00);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_rsp_err",   bus.rsp_err, 1'b0);
    chk("rst_psel",      bus.psel, 1'b0);
    chk("rst_penable",   bus.penable, 1'b0);
    chk("rst_pwrite",    bus.pwrite, 1'b0);
    chk("rst_paddr",     bus.paddr, 12'h0);
    chk("rst_pwdata",    bus.pwdata, 32'h0);
    chk("rst_timeout",   timeout, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Contention from reset: three writes each, alternating grants 2 cycles apart
    for (int i = 0; i < 3; i++) begin
      cq[0].push_back('{w: 1'b1, a: 12'h010 + 12'(4 * i), d: $urandom});
      cq[1].push_back('{w: 1'b1, a: 12'h020 + 12'(4 * i), d: $urandom});
    end
    glog.delete();
    gcyc.delete();
    feed();
    for (int i = 0; i < 40; i++) begin
      tick();
      feed();
      if (cq[0].size() == 0 && cq[1].size() == 0 && bus.req_valid == 2'b00 && m_owner < 0) break;
    end
    chk("cont_grant_count", glog.size(), 6);
    for (int i = 0; i < glog.size(); i++) begin
      chk("cont_grant_order", glog[i], i % 2);
      if (i > 0) chk("cont_grant_spacing", gcyc[i] - gcyc[i-1], 2);
    end

    // Single zero-wait read
    bus.prdata = 32'hDEAD_BEEF;
    bus.pready = 1'b1;
    present(0, '{w: 1'b0, a: 12'h004, d: 32'h0});
    tick();
    chk("sr_ready", s_ready, 2'b01);
    tick();
    chk("sr_setup_psel", s_psel, 1'b1);
    chk("sr_setup_pen",  s_pen, 1'b0);
    tick();
    chk("sr_access_pen", s_pen, 1'b1);
    chk("sr_rsp",        s_rsp, 2'b01);
    chk("sr_rdata",      s_rdata, 32'hDEAD_BEEF);
    chk("sr_err",        s_err, 1'b0);
    tick();
    chk("sr_idle_psel",  s_psel, 1'b0);

    // Wait states then slave error on a write
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    present(1, '{w: 1'b1, a: 12'h00C, d: 32'h1234_5678});
    tick();
    tick();
    npen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      npen += int'(s_pen);
    end
    bus.pready  = 1'b1;
    bus.pslverr = 1'b1;
    tick();
    npen += int'(s_pen);
    chk("ws_pen_cycles", npen, 6);
    chk("ws_err",        s_err, 1'b1);
    chk("ws_rsp",        s_rsp, 2'b10);
    bus.pslverr = 1'b0;
    tick();

    // Slave never ready
    bus.pready = 1'b0;
    bus.prdata = 32'hA5A5_A5A5;
    present(0, '{w: 1'b0, a: 12'h008, d: 32'h0});
    tick();
    tick();
    npen = 0;
    ntmo = 0;
`ifdef APB_TIMER_ARBITER_TIMEOUT_EN
    for (int i = 0; i < TMO_CYC; i++) begin
      tick();
      npen += int'(s_pen);
      ntmo += int'(s_tmo);
    end
    chk("to_pulse",  ntmo, 1);
    chk("to_pen",    npen, TMO_CYC);
    chk("to_rsp",    s_rsp, 2'b01);
    chk("to_err",    s_err, 1'b1);
    chk("to_rdata",  s_rdata, 32'h0);
    tick();
    chk("to_psel_drop", s_psel, 1'b0);
    bus.pready = 1'b1;
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      npen += int'(s_pen);
      ntmo += int'(s_tmo);
    end
    chk("nt_tmo", ntmo, 0);
    chk("nt_pen", npen, 20);
    bus.pready = 1'b1;
    tick();
    chk("nt_rsp",   s_rsp, 2'b01);
    chk("nt_rdata", s_rdata, 32'hA5A5_A5A5);
    tick();
`endif

    // Reset in the middle of ACCESS
    bus.pready = 1'b0;
    present(1, '{w: 1'b0, a: 12'h010, d: 32'h0});
    tick();
    tick();
    bus.pready = 1'b1;
    #1;
    chk("rm_pre_rsp", bus.rsp_valid, 2'b10);
    reset = 1'b1;
    #1;
    chk("rm_psel",    bus.psel, 1'b0);
    chk("rm_penable", bus.penable, 1'b0);
    chk("rm_rsp",     bus.rsp_valid, 2'b00);
    @(posedge clk);
    #1;
    model_reset();
    present(0, '{w: 1'b1, a: 12'h030, d: 32'hCAFE_0000});
    present(1, '{w: 1'b1, a: 12'h034, d: 32'hCAFE_0001});
    reset = 1'b0;
    tick();
    chk("rm_tie_grant", s_ready, 2'b01);
    for (int i = 0; i < 6; i++) tick();

    // Randomized traffic with wait states, errors and withdrawals
    for (int i = 0; i < 300; i++) begin
      for (int r = 0; r < 2; r++) begin
        if (!bus.req_valid[r]) begin
          if ($urandom_range(2) == 0) begin
            c.w = 1'($urandom);
            c.a = 12'($urandom);
            c.d = $urandom;
            present(r, c);
          end
        end else if ($urandom_range(15) == 0) begin
          bus.req_valid[r] = 1'b0;
        end
      end
      bus.pready  = ($urandom_range(9) < 7);
      bus.pslverr = ($urandom_range(7) == 0);
      bus.prdata  = $urandom;
      tick();
    end
    bus.req_valid = 2'b00;
    bus.pready    = 1'b1;
    bus.pslverr   = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
